vga_fb_ctrl: RTL and testbench
==============================

# vga_fb_ctrl

Parametrised framebuffer controller between a byte-stream source (UART receiver) and the `vga` timing core. It decodes a small command protocol into pixel writes, palette updates, address moves and full-frame clears. It stores FB_W x FB_H pixels of BPP bits in inferred dual-port RAM. It returns palette-mapped, integer-scaled 6-bit colour for the coordinates the timing core requests.

## Interface
- FB_W, 180: framebuffer width in pixels
- FB_H, 180: framebuffer height in pixels
- BPP, 2: bits per pixel; legal values 1, 2, 4
- SCALE_LOG2, 0: each stored pixel covers 2^SCALE_LOG2 x 2^SCALE_LOG2 screen pixels
- H_WIDTH, 10: width of horizontal coordinate
- V_WIDTH, 10: width of vertical coordinate
- ADDR_W, 16: pixel address width; FB_W*FB_H must be at most 2^ADDR_W

Ports:
- i_clk  in  1  clock, the only clock
- i_nrst  in  1  asynchronous active-low reset
- i_valid  in  1  command/data byte valid
- i_data  in  8  command/data byte
- o_ready  out  1  byte accepted when i_valid & o_ready
- o_ack  out  1  one-cycle pulse when a command completes
- o_err  out  1  one-cycle pulse on an unknown opcode
- i_h  in  H_WIDTH  next horizontal coordinate from timing core
- i_v  in  V_WIDTH  next vertical coordinate from timing core
- o_rgb  out  6  {r[1:0],g[1:0],b[1:0]} for the pixel at (i_h,i_v) two cycles earlier

## Operation
- FSM states: IDLE, ADDR_LO, ADDR_HI, CNT, DATA, UNPACK, PAL_IDX, PAL_COL, CLR_VAL, CLEAR.
- IDLE: the accepted byte is the opcode.
- 0x01 SET_ADDR: ADDR_LO then ADDR_HI. Pointer = {hi,lo} truncated to ADDR_W. Values >= FB_W*FB_H become 0. o_ack follows the high byte.
- 0x02 WRITE: CNT byte N gives N data bytes, with 0 meaning 256. Each data byte is accepted in DATA, then UNPACK writes 8/BPP pixels, LSB-first, one per cycle. The pointer post-increments per pixel and wraps from FB_W*FB_H-1 to 0. o_ready stays low through UNPACK. o_ack follows the final pixel write.
- 0x03 SET_PAL: PAL_IDX then PAL_COL. The entry at index[BPP-1:0] is set to colour[5:0]. o_ack follows.
- 0x04 CLEAR: CLR_VAL then CLEAR. CLEAR writes value[BPP-1:0] to every address 0..FB_W*FB_H-1, one per cycle, with o_ready low. The pointer is then 0 and o_ack pulses.
- Any other opcode: o_err pulses, FSM stays IDLE, byte is consumed.
- o_ready is high in all states except UNPACK and CLEAR.
- Read path:
  - xs = i_h >> SCALE_LOG2, ys = i_v >> SCALE_LOG2.
  - in_frame = (xs < FB_W) & (ys < FB_H).
  - Address = ys*FB_W + xs when in_frame, else 0.
  - RAM read is synchronous. Palette lookup is registered into o_rgb.
  - Out-of-frame pixels give 6'b000000.
  - Palette entry 0 is also the background colour.
- Palette reset values: entry0 000000, entry1 110000, entry2 111100, entry3 001100, all higher entries 111111.
- RAM contents are not reset.

## Timing
- Reset values: o_ready 1, o_ack 0, o_err 0, o_rgb 0, FSM IDLE, pointer 0, palette at defaults.
- Reset asserted mid-command or mid-CLEAR aborts immediately. Already-written pixels keep their values.
- Read latency: o_rgb reflects (i_h,i_v) presented at cycle t on cycle t+2. in_frame is pipelined alongside.
- Write/read collision at the same address in the same cycle: the read returns old data. The new data is visible from the next read.
- Palette write and lookup in the same cycle: the lookup uses the old entry.
- WRITE throughput: one data byte per 8/BPP+1 cycles. CLEAR duration: FB_W*FB_H cycles.
- o_ack and o_err are never high together. Each pulse lasts exactly one cycle.
- The read path is never stalled by the write FSM.

## Test plan
- Reset defaults: release reset with i_h=i_v=0 and RAM preloaded to 0 -> o_rgb=000000 on cycle 2, o_ready=1, no ack/err.
- WRITE/readback, BPP=2: bytes 01 00 00, 02 01 E4 -> pixels 0..3 = 0,1,2,3. Sweep i_h 0..3 at v=0 -> o_rgb 000000, 110000, 111100, 001100, each 2 cycles later.
- Wrap and scaling, FB_W=FB_H=4, SCALE_LOG2=1: SET_ADDR 15, WRITE 1 byte 0x55 -> addr 15 and addrs 0..2 = 1. (i_h,i_v)=(7,7) -> 110000. (8,0) -> 000000.
- SET_PAL and CLEAR: 03 00 3F, then 04 00 -> o_ready low for exactly FB_W*FB_H cycles, then one o_ack. Every in-frame pixel reads 111111.
- Error and backpressure: opcode 0x7E -> single o_err, FSM stays IDLE. Hold i_valid high through a WRITE -> no byte lost, none accepted while o_ready=0.
- Reset mid-CLEAR: assert i_nrst low halfway -> o_ready=1 and FSM IDLE after release. The first half of the pixels hold the clear value, the rest are unchanged.

Source files
------------

// File: rtl/vga_fb_ctrl.sv
// rtl/vga_fb_ctrl.sv - byte-command framebuffer controller feeding palette-mapped pixels to the vga timing core.
// A command FSM writes pixels, palette entries and clears; an independent two-stage read path serves the display.
module vga_fb_ctrl #(
   parameter int FB_W       = 180,
   parameter int FB_H       = 180,
   parameter int BPP        = 2,
   parameter int SCALE_LOG2 = 0,
   parameter int H_WIDTH    = 10,
   parameter int V_WIDTH    = 10,
   parameter int ADDR_W     = 16
) (
   input  logic               i_clk,
   input  logic               i_nrst,
   input  logic               i_valid,
   input  logic [7:0]         i_data,
   output logic               o_ready,
   output logic               o_ack,
   output logic               o_err,
   input  logic [H_WIDTH-1:0] i_h,
   input  logic [V_WIDTH-1:0] i_v,
   output logic [5:0]         o_rgb
);

   localparam int NPIX   = FB_W * FB_H;
   localparam int MEM_AW = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam int PPB    = 8 / BPP;
   localparam int PAL_N  = 1 << BPP;

   function automatic logic [PAL_N*6-1:0] pal_init();
      logic [PAL_N*6-1:0] v;
      for (int i = 0; i < PAL_N; i++) begin
         case (i)
            0:       v[6*i +: 6] = 6'b000000;
            1:       v[6*i +: 6] = 6'b110000;
            2:       v[6*i +: 6] = 6'b111100;
            3:       v[6*i +: 6] = 6'b001100;
            default: v[6*i +: 6] = 6'b111111;
         endcase
      end
      return v;
   endfunction

   localparam logic [PAL_N*6-1:0] PAL_RST = pal_init();

   typedef enum logic [3:0] {
      IDLE, ADDR_LO, ADDR_HI, CNT, DATA, UNPACK, PAL_IDX, PAL_COL, CLR_VAL, CLEAR
   } state_t;

   state_t             state, state_d;
   logic [ADDR_W-1:0]  ptr, ptr_inc, addr_set;
   logic [7:0]         addr_lo, data_sh;
   logic [8:0]         cnt;
   logic [2:0]         sub;
   logic [BPP-1:0]     pal_idx, clr_val, wr_val, rd_pix;
   logic [PAL_N*6-1:0] pal;
   logic               accept, wr_en, ptr_last, last_pix, ack_d, err_d;

   logic [BPP-1:0]     mem [0:NPIX-1];

   assign o_ready  = (state != UNPACK) && (state != CLEAR);
   assign accept   = i_valid && o_ready;
   assign ptr_last = (32'(ptr) == NPIX - 1);
   assign ptr_inc  = ptr_last ? '0 : ptr + ADDR_W'(1);
   assign addr_set = ADDR_W'({i_data, addr_lo});
   assign wr_en    = (state == UNPACK) || (state == CLEAR);
   assign wr_val   = (state == CLEAR) ? clr_val : data_sh[BPP-1:0];
   assign last_pix = (sub == 3'(PPB - 1));

   always_comb begin
      state_d = state;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      case (state)
         IDLE: if (accept) begin
            case (i_data)
               8'h01:   state_d = ADDR_LO;
               8'h02:   state_d = CNT;
               8'h03:   state_d = PAL_IDX;
               8'h04:   state_d = CLR_VAL;
               default: err_d   = 1'b1;
            endcase
         end
         ADDR_LO: if (accept) state_d = ADDR_HI;
         ADDR_HI: if (accept) begin
            state_d = IDLE;
            ack_d   = 1'b1;
         end
         CNT:     if (accept) state_d = DATA;
         DATA:    if (accept) state_d = UNPACK;
         UNPACK:  if (last_pix) begin
            if (cnt == 9'd1) begin
               state_d = IDLE;
               ack_d   = 1'b1;
            end else begin
               state_d = DATA;
            end
         end
         PAL_IDX: if (accept) state_d = PAL_COL;
         PAL_COL: if (accept) begin
            state_d = IDLE;
            ack_d   = 1'b1;
         end
         CLR_VAL: if (accept) state_d = CLEAR;
         CLEAR:   if (ptr_last) begin
            state_d = IDLE;
            ack_d   = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state   <= IDLE;
         ptr     <= '0;
         addr_lo <= '0;
         data_sh <= '0;
         cnt     <= '0;
         sub     <= '0;
         pal_idx <= '0;
         clr_val <= '0;
         pal     <= PAL_RST;
         o_ack   <= 1'b0;
         o_err   <= 1'b0;
      end else begin
         state <= state_d;
         o_ack <= ack_d;
         o_err <= err_d;
         case (state)
            ADDR_LO: if (accept) addr_lo <= i_data;
            ADDR_HI: if (accept) ptr <= (32'(addr_set) >= NPIX) ? '0 : addr_set;
            CNT:     if (accept) cnt <= (i_data == 8'd0) ? 9'd256 : {1'b0, i_data};
            DATA:    if (accept) begin
               data_sh <= i_data;
               sub     <= '0;
            end
            UNPACK: begin
               data_sh <= data_sh >> BPP;
               sub     <= sub + 3'd1;
               ptr     <= ptr_inc;
               if (last_pix) cnt <= cnt - 9'd1;
            end
            PAL_IDX: if (accept) pal_idx <= i_data[BPP-1:0];
            PAL_COL: if (accept) pal[6*int'(pal_idx) +: 6] <= i_data[5:0];
            CLR_VAL: if (accept) begin
               clr_val <= i_data[BPP-1:0];
               ptr     <= '0;
            end
            CLEAR:   ptr <= ptr_inc;
            default: ;
         endcase
      end
   end

   // Display read path: coordinate -> address, RAM read, palette lookup.
   logic [H_WIDTH-1:0] xs;
   logic [V_WIDTH-1:0] ys;
   logic               in_frame, in_frame_q;
   logic [MEM_AW-1:0]  rd_addr;

   assign xs       = i_h >> SCALE_LOG2;
   assign ys       = i_v >> SCALE_LOG2;
   assign in_frame = (32'(xs) < FB_W) && (32'(ys) < FB_H);
   assign rd_addr  = in_frame ? MEM_AW'(ys) * MEM_AW'(FB_W) + MEM_AW'(xs) : '0;

   // Read-before-write: a same-address collision returns the old pixel.
   always_ff @(posedge i_clk) begin
      if (wr_en) mem[ptr[MEM_AW-1:0]] <= wr_val;
      rd_pix <= mem[rd_addr];
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         in_frame_q <= 1'b0;
         o_rgb      <= '0;
      end else begin
         in_frame_q <= in_frame;
         o_rgb      <= in_frame_q ? pal[6*int'(rd_pix) +: 6] : 6'b000000;
      end
   end

endmodule

// File: tb/tb_vga_fb_ctrl.sv
// tb/tb_vga_fb_ctrl.sv - directed self-checking bench for vga_fb_ctrl on a 4x4, 2bpp, 2x-scaled frame.
module tb_vga_fb_ctrl;

   localparam int FB_W = 4;
   localparam int FB_H = 4;
   localparam int NPIX = FB_W * FB_H;

   logic       i_clk = 1'b0;
   logic       i_nrst = 1'b0;
   logic       i_valid = 1'b0;
   logic [7:0] i_data = 8'h00;
   logic       o_ready, o_ack, o_err;
   logic [9:0] i_h = '0;
   logic [9:0] i_v = '0;
   logic [5:0] o_rgb;

   vga_fb_ctrl #(
      .FB_W(FB_W), .FB_H(FB_H), .BPP(2), .SCALE_LOG2(1),
      .H_WIDTH(10), .V_WIDTH(10), .ADDR_W(16)
   ) dut (
      .i_clk(i_clk), .i_nrst(i_nrst), .i_valid(i_valid), .i_data(i_data),
      .o_ready(o_ready), .o_ack(o_ack), .o_err(o_err),
      .i_h(i_h), .i_v(i_v), .o_rgb(o_rgb)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0, errors = 0;
   int ack_cnt = 0, err_cnt = 0, both_cnt = 0, exp_ack = 0;

   always @(negedge i_clk) begin
      if (i_nrst) begin
         if (o_ack) ack_cnt++;
         if (o_err) err_cnt++;
         if (o_ack && o_err) both_cnt++;
      end
   end

   typedef struct {
      int         phase;
      int         h;
      int         v;
      logic [5:0] rgb;
   } vec_t;

   vec_t vecs[64];
   int   nv = 0;

   task automatic add_vec(input int p, input int h, input int v, input logic [5:0] rgb);
      vecs[nv] = '{p, h, v, rgb};
      nv++;
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge i_clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      i_valid = 1'b1;
      i_data  = b;
      while (!o_ready && n < 2000) begin
         @(negedge i_clk);
         n++;
      end
      if (!o_ready) check("send_timeout", 0, 1);
      @(negedge i_clk);
      i_valid = 1'b0;
   endtask

   task automatic wait_ready(output int lows);
      lows = 0;
      while (!o_ready && lows < 2000) begin
         @(negedge i_clk);
         lows++;
      end
   endtask

   task automatic check_acks(input string name);
      #1;
      check(name, ack_cnt, exp_ack);
      @(negedge i_clk);
   endtask

   // Presents one coordinate per cycle and checks o_rgb two cycles later.
   task automatic run_phase(input int p);
      int q[$];
      for (int i = 0; i < nv; i++) if (vecs[i].phase == p) q.push_back(i);
      for (int j = 0; j < q.size() + 2; j++) begin
         if (j >= 2)
            check($sformatf("rd p%0d (%0d,%0d)", p, vecs[q[j-2]].h, vecs[q[j-2]].v),
                  int'(o_rgb), int'(vecs[q[j-2]].rgb));
         if (j < q.size()) begin
            i_h = 10'(vecs[q[j]].h);
            i_v = 10'(vecs[q[j]].v);
         end
         @(negedge i_clk);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lows, k, cyc, lowcyc;
      logic [7:0] bs [4];

      add_vec(1, 0, 0, 6'b000000); add_vec(1, 2, 0, 6'b110000);
      add_vec(1, 4, 0, 6'b111100); add_vec(1, 6, 0, 6'b001100);
      add_vec(1, 3, 1, 6'b110000); add_vec(1, 7, 1, 6'b001100);
      add_vec(1, 8, 0, 6'b000000); add_vec(1, 0, 2, 6'b000000);
      add_vec(2, 7, 7, 6'b110000); add_vec(2, 6, 6, 6'b110000);
      add_vec(2, 8, 0, 6'b000000); add_vec(2, 0, 8, 6'b000000);
      add_vec(2, 0, 0, 6'b110000); add_vec(2, 4, 1, 6'b110000);
      add_vec(2, 6, 0, 6'b001100); add_vec(2, 4, 6, 6'b000000);
      add_vec(3, 0, 0, 6'b001100); add_vec(3, 2, 0, 6'b111100);
      add_vec(3, 4, 0, 6'b110000); add_vec(3, 6, 0, 6'b000000);
      add_vec(3, 0, 2, 6'b000000); add_vec(3, 2, 2, 6'b110000);
      add_vec(3, 5, 3, 6'b111100); add_vec(3, 7, 3, 6'b001100);
      add_vec(3, 7, 7, 6'b110000);
      add_vec(4, 1, 1, 6'b000000); add_vec(4, 2, 2, 6'b110000);
      add_vec(4, 5, 5, 6'b111100); add_vec(4, 7, 7, 6'b001100);
      add_vec(4, 6, 0, 6'b001100); add_vec(4, 0, 6, 6'b000000);
      add_vec(5, 0, 0, 6'b111111); add_vec(5, 7, 7, 6'b111111);
      add_vec(5, 3, 5, 6'b111111); add_vec(5, 6, 2, 6'b111111);
      add_vec(5, 8, 8, 6'b000000); add_vec(5, 9, 0, 6'b000000);
      add_vec(6, 0, 0, 6'b111100); add_vec(6, 6, 2, 6'b111100);
      add_vec(6, 0, 4, 6'b110000); add_vec(6, 7, 7, 6'b110000);
      add_vec(6, 7, 3, 6'b111100); add_vec(6, 2, 4, 6'b110000);

      // Reset defaults
      tick(3);
      check("rst_ready", int'(o_ready), 1);
      check("rst_ack", int'(o_ack), 0);
      check("rst_err", int'(o_err), 0);
      check("rst_rgb", int'(o_rgb), 0);
      i_nrst = 1'b1;

      // Zero the RAM, then re-reset and read (0,0) two cycles after release
      send_byte(8'h04); send_byte(8'h00);
      wait_ready(lows);
      check("clear0_len", lows, NPIX);
      check("clear0_ack", int'(o_ack), 1);
      exp_ack++;
      check_acks("acks_clear0");
      i_nrst = 1'b0;
      tick(2);
      i_nrst = 1'b1;
      tick(2);
      check("rgb_after_reset", int'(o_rgb), 0);
      check("ready_after_reset", int'(o_ready), 1);

      // WRITE/readback
      send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
      check("setaddr_ack", int'(o_ack), 1);
      exp_ack++;
      send_byte(8'h02); send_byte(8'h01); send_byte(8'hE4);
      wait_ready(lows);
      check("unpack_len", lows, 4);
      check("write_ack", int'(o_ack), 1);
      exp_ack++;
      check_acks("acks_p1");
      run_phase(1);

      // Pointer wrap from last pixel to 0
      send_byte(8'h01); send_byte(8'h0F); send_byte(8'h00);
      send_byte(8'h02); send_byte(8'h01); send_byte(8'h55);
      wait_ready(lows);
      exp_ack += 2;
      check_acks("acks_p2");
      run_phase(2);

      // Out-of-range SET_ADDR, then a WRITE with i_valid held high
      send_byte(8'h01); send_byte(8'h10); send_byte(8'h00);
      exp_ack++;
      bs[0] = 8'h02; bs[1] = 8'h02; bs[2] = 8'h1B; bs[3] = 8'hE4;
      k = 0; cyc = 0; lowcyc = 0;
      i_valid = 1'b1;
      while (k < 4 && cyc < 200) begin
         i_data = bs[k];
         if (o_ready) k++;
         else lowcyc++;
         @(negedge i_clk);
         cyc++;
      end
      i_valid = 1'b0;
      check("bp_bytes", k, 4);
      check("bp_stall_cycles", lowcyc, 4);
      check("bp_throughput", cyc, 8);
      wait_ready(lows);
      check("bp_last_unpack", lows, 4);
      exp_ack++;
      check_acks("acks_p3");
      run_phase(3);

      // Count byte 0 means 256 data bytes
      send_byte(8'h02); send_byte(8'h00);
      for (int b = 0; b < 255; b++) send_byte((b >= 252) ? 8'hE4 : 8'h00);
      wait_ready(lows);
      check_acks("no_early_ack");
      send_byte(8'hE4);
      wait_ready(lows);
      check("cnt256_ack", int'(o_ack), 1);
      exp_ack++;
      check_acks("acks_p4");
      run_phase(4);

      // Unknown opcode
      send_byte(8'h7E);
      check("err_pulse", int'(o_err), 1);
      check("err_no_ack", int'(o_ack), 0);
      tick(1);
      check("err_one_cycle", int'(o_err), 0);
      check("err_ready", int'(o_ready), 1);
      #1;
      check("err_count", err_cnt, 1);
      @(negedge i_clk);

      // SET_PAL entry 0, then CLEAR to 0
      send_byte(8'h03); send_byte(8'h00); send_byte(8'h3F);
      check("setpal_ack", int'(o_ack), 1);
      send_byte(8'h04); send_byte(8'h00);
      wait_ready(lows);
      check("clear_len", lows, NPIX);
      check("clear_ack", int'(o_ack), 1);
      exp_ack += 2;
      check_acks("acks_p5");
      run_phase(5);

      // Reset halfway through a CLEAR
      send_byte(8'h04); send_byte(8'h01);
      wait_ready(lows);
      exp_ack++;
      send_byte(8'h04); send_byte(8'h02);
      tick(NPIX / 2);
      i_nrst = 1'b0;
      #1;
      check("midclr_ready", int'(o_ready), 1);
      check("midclr_ack", int'(o_ack), 0);
      tick(2);
      i_nrst = 1'b1;
      tick(1);
      run_phase(6);
      send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
      check("idle_after_reset", int'(o_ack), 1);
      exp_ack++;
      check_acks("acks_final");
      check("ack_err_exclusive", both_cnt, 0);
      check("err_total", err_cnt, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
